adc_bank_sched: RTL and testbench

- Scheduler that sequences the ADC-FIFO-to-RAM copy engine over a ping-pong RAM of two banks.
- Starts one copy (8 chips x 64 bytes) into the current write bank whenever every chip FIFO holds a full frame and a bank is free.
- Hands each filled bank, in order, to the downstream frame sender and frees the bank when the sender finishes.
- Sits between the per-chip ADC FIFOs, the copy engine (fs/fd handshake, base-address input) and the packet transmitter.

---
 rtl/adc_bank_sched_pkg.sv | 44 ++++
 rtl/adc_bank_sched_fs_fd_hs.sv | 71 +++++++
 rtl/adc_bank_sched.sv | 194 +++++++++++++++++++
 tb/tb_adc_bank_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_bank_sched_pkg.sv
// rtl/adc_bank_sched_pkg.sv - shared encodings and constants for the ADC bank scheduler
//
// Contents:
//   DATA_LEN, CHIP_LEN          frame geometry shared with the copy engine
//   DEF_BANK_BASE/DEF_BANK_SIZE default ping-pong bank layout
//   wr_state_e / rd_state_e     write-side and read-side FSM encodings
//   hs_state_e                  fs/fd handshake master encoding
//   bank_addr()                 base address of bank 0 or bank 1

package adc_bank_sched_pkg;

  localparam logic [7:0]  DATA_LEN      = 8'h40;
  localparam int          CHIP_LEN      = 8;
  localparam logic [11:0] DEF_BANK_BASE = 12'h000;
  localparam logic [11:0] DEF_BANK_SIZE = 12'h200;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_WAIT   = 3'd1,
    W_FILL   = 3'd2,
    W_REL    = 3'd3,
    W_COMMIT = 3'd4
  } wr_state_e;

  typedef enum logic [1:0] {
    R_WAIT = 2'd0,
    R_SEND = 2'd1,
    R_REL  = 2'd2,
    R_FREE = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_START   = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_e;

  function automatic logic [11:0] bank_addr(input logic [11:0] base,
                                            input logic [11:0] size,
                                            input logic        bank);
    return bank ? (base + size) : base;
  endfunction

endpackage

// File: rtl/adc_bank_sched_fs_fd_hs.sv
// rtl/adc_bank_sched_fs_fd_hs.sv - generic 4-phase fs/fd level-handshake master
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start_i    request a transaction (sampled only while idle)
//   abort_i    drop any transaction in flight and return to idle
//   fd_i       done level from the slave
//   fs_o       registered start level to the slave
//   ack_o      strobe: slave raised fd while fs is high
//   done_o     strobe: slave dropped fd after release (transaction complete)

module fs_fd_hs
  import adc_bank_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic abort_i,
  input  logic fd_i,
  output logic fs_o,
  output logic ack_o,
  output logic done_o
);

  hs_state_e state_q, state_d;
  logic      fs_q, fs_d;

  always_comb begin
    state_d = state_q;
    ack_o   = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (start_i) state_d = HS_START;
      end
      HS_START: begin
        if (fd_i) begin
          state_d = HS_RELEASE;
          ack_o   = 1'b1;
        end
      end
      HS_RELEASE: begin
        if (!fd_i) begin
          state_d = HS_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = HS_IDLE;
    endcase
    if (abort_i) begin
      state_d = HS_IDLE;
      ack_o   = 1'b0;
      done_o  = 1'b0;
    end
    // fs follows the next state so it is a clean flop output, high exactly in HS_START
    fs_d = (state_d == HS_START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HS_IDLE;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fs_q    <= fs_d;
    end
  end

  assign fs_o = fs_q;

endmodule

// File: rtl/adc_bank_sched.sv
// rtl/adc_bank_sched.sv - ping-pong bank scheduler between ADC FIFOs, copy engine and frame sender
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       allow new copy starts (level)
//   fifo_ready   per-chip flag: FIFO holds a full 64-byte frame
//   cp_fs/cp_fd  start/done levels to/from the copy engine
//   cp_addr      bank base address for the copy engine
//   tx_fs/tx_fd  start/done levels to/from the frame sender
//   tx_addr      bank base address to send
//   tx_frame     sequence number of the frame being sent
//   ovf_cnt      saturating count of blocked-frame events
//   busy         a copy is in progress

module adc_bank_sched
  import adc_bank_sched_pkg::*;
#(
  parameter logic [11:0] BANK_BASE = DEF_BANK_BASE,
  parameter logic [11:0] BANK_SIZE = DEF_BANK_SIZE,
  parameter int          CHIP_NUM  = CHIP_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CHIP_NUM-1:0] fifo_ready,
  output logic                cp_fs,
  input  logic                cp_fd,
  output logic [11:0]         cp_addr,
  output logic                tx_fs,
  input  logic                tx_fd,
  output logic [11:0]         tx_addr,
  output logic [15:0]         tx_frame,
  output logic [7:0]          ovf_cnt,
  output logic                busy
);

  wr_state_e        wr_state_q, wr_state_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [15:0]      wr_frame_q, wr_frame_d;
  logic [1:0][15:0] id_q, id_d;
  logic [11:0]      cp_addr_q, cp_addr_d;
  logic [11:0]      tx_addr_q, tx_addr_d;
  logic [15:0]      tx_frame_q, tx_frame_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             blocked_q, blocked_d;
  logic             busy_q, busy_d;

  logic all_rdy, free, wr_go, rd_go, blocked;
  logic wr_bad, rd_bad;
  logic cp_ack, cp_done, tx_ack, tx_done;

  assign all_rdy = &fifo_ready;
  assign free    = ~full_q[wr_bank_q];
  assign wr_go   = enable & all_rdy & free;
  assign rd_go   = full_q[rd_bank_q];
  assign blocked = (wr_state_q == W_WAIT) & enable & all_rdy & ~free;

  fs_fd_hs u_cp_hs (
    .clk     (clk),
    .rst     (rst),
    .start_i (wr_state_q == W_FILL),
    .abort_i (wr_bad),
    .fd_i    (cp_fd),
    .fs_o    (cp_fs),
    .ack_o   (cp_ack),
    .done_o  (cp_done)
  );

  fs_fd_hs u_tx_hs (
    .clk     (clk),
    .rst     (rst),
    .start_i (rd_state_q == R_SEND),
    .abort_i (rd_bad),
    .fd_i    (tx_fd),
    .fs_o    (tx_fs),
    .ack_o   (tx_ack),
    .done_o  (tx_done)
  );

  // Write FSM: the handshake master owns fs; this FSM tracks the phase via its strobes
  always_comb begin
    wr_state_d = wr_state_q;
    wr_bad     = 1'b0;
    case (wr_state_q)
      W_IDLE:   wr_state_d = W_WAIT;
      W_WAIT:   if (wr_go) wr_state_d = W_FILL;
      W_FILL:   if (cp_ack) wr_state_d = W_REL;
      W_REL:    if (cp_done) wr_state_d = W_COMMIT;
      W_COMMIT: wr_state_d = W_WAIT;
      default: begin
        wr_state_d = W_IDLE;
        wr_bad     = 1'b1;
      end
    endcase
  end

  // Read FSM
  always_comb begin
    rd_state_d = rd_state_q;
    rd_bad     = 1'b0;
    case (rd_state_q)
      R_WAIT: if (rd_go) rd_state_d = R_SEND;
      R_SEND: if (tx_ack) rd_state_d = R_REL;
      R_REL:  if (tx_done) rd_state_d = R_FREE;
      R_FREE: rd_state_d = R_WAIT;
      default: begin
        rd_state_d = R_WAIT;
        rd_bad     = 1'b1;
      end
    endcase
  end

  // Bank bookkeeping and output registers
  always_comb begin
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    wr_frame_d = wr_frame_q;
    id_d       = id_q;
    cp_addr_d  = cp_addr_q;
    tx_addr_d  = tx_addr_q;
    tx_frame_d = tx_frame_q;
    ovf_d      = ovf_q;
    blocked_d  = blocked;
    busy_d     = (wr_state_d != W_WAIT) && (wr_state_d != W_IDLE);

    // cp_addr is latched on W_FILL entry, one cycle before cp_fs rises
    if (wr_state_q == W_WAIT && wr_go)
      cp_addr_d = bank_addr(BANK_BASE, BANK_SIZE, wr_bank_q);

    if (wr_state_q == W_COMMIT) begin
      full_d[wr_bank_q] = 1'b1;
      id_d[wr_bank_q]   = wr_frame_q;
      wr_bank_d         = ~wr_bank_q;
      wr_frame_d        = wr_frame_q + 16'd1;
    end

    if (rd_state_q == R_WAIT && rd_go) begin
      tx_addr_d  = bank_addr(BANK_BASE, BANK_SIZE, rd_bank_q);
      tx_frame_d = id_q[rd_bank_q];
    end

    // A commit and a free in the same cycle always hit different banks, so both apply
    if (rd_state_q == R_FREE) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (blocked && !blocked_q && ovf_q != 8'hFF)
      ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_WAIT;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      wr_frame_q <= 16'd0;
      id_q       <= '0;
      cp_addr_q  <= BANK_BASE;
      tx_addr_q  <= BANK_BASE;
      tx_frame_q <= 16'd0;
      ovf_q      <= 8'd0;
      blocked_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      wr_frame_q <= wr_frame_d;
      id_q       <= id_d;
      cp_addr_q  <= cp_addr_d;
      tx_addr_q  <= tx_addr_d;
      tx_frame_q <= tx_frame_d;
      ovf_q      <= ovf_d;
      blocked_q  <= blocked_d;
      busy_q     <= busy_d;
    end
  end

  assign cp_addr  = cp_addr_q;
  assign tx_addr  = tx_addr_q;
  assign tx_frame = tx_frame_q;
  assign ovf_cnt  = ovf_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_adc_bank_sched.sv
// tb/tb_adc_bank_sched.sv - self-checking bench for adc_bank_sched

module tb_adc_bank_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  fifo_ready = 8'h00;
  logic        cp_fs;
  logic        cp_fd = 1'b0;
  logic [11:0] cp_addr;
  logic        tx_fs;
  logic        tx_fd = 1'b0;
  logic [11:0] tx_addr;
  logic [15:0] tx_frame;
  logic [7:0]  ovf_cnt;
  logic        busy;

  adc_bank_sched dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_ready (fifo_ready),
    .cp_fs      (cp_fs),
    .cp_fd      (cp_fd),
    .cp_addr    (cp_addr),
    .tx_fs      (tx_fs),
    .tx_fd      (tx_fd),
    .tx_addr    (tx_addr),
    .tx_frame   (tx_frame),
    .ovf_cnt    (ovf_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] frame;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  int cp_delay  = 20;
  int tx_delay  = 5;
  bit tx_block  = 1'b0;
  bit sync_mode = 1'b0;

  int          cp_st = 0, tx_st = 0, cp_cnt = 0, tx_cnt = 0;
  int          n_cp_start = 0, n_cp_done = 0, n_sent = 0;
  bit          m_wr_bank = 1'b0;
  logic [15:0] m_wr_frame = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] exp_addr(input bit b);
    return b ? 12'h200 : 12'h000;
  endfunction

  // Copy-engine and frame-sender models; both act on the falling edge
  initial begin : models
    int   cp_st0, tx_st0;
    bit   cp_drop, tx_drop;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cp_fd = 1'b0; tx_fd = 1'b0;
        cp_st = 0; tx_st = 0; cp_cnt = 0; tx_cnt = 0;
        n_cp_start = 0; n_cp_done = 0; n_sent = 0;
        m_wr_bank = 1'b0; m_wr_frame = 16'd0;
        sb.delete();
      end else begin
        cp_st0  = cp_st;
        tx_st0  = tx_st;
        cp_drop = (cp_st0 == 3) && (!sync_mode || tx_st0 == 3 || (tx_st0 == 0 && !tx_fs));
        tx_drop = (tx_st0 == 3) && (!sync_mode || cp_st0 == 3 || (cp_st0 == 0 && !busy));
        case (cp_st0)
          0: if (cp_fs) begin
               chk("cp_addr", 32'(cp_addr), 32'(exp_addr(m_wr_bank)));
               chk("cp_busy", 32'(busy), 32'd1);
               n_cp_start++;
               cp_cnt = 0;
               cp_st  = 1;
             end
          1: begin
               cp_cnt++;
               if (cp_cnt >= cp_delay) begin cp_fd = 1'b1; cp_st = 2; end
             end
          2: if (!cp_fs) cp_st = 3;
          default: if (cp_drop) begin
               cp_fd = 1'b0;
               sb.push_back(exp_t'{exp_addr(m_wr_bank), m_wr_frame});
               m_wr_frame = m_wr_frame + 16'd1;
               m_wr_bank  = ~m_wr_bank;
               n_cp_done++;
               cp_st = 0;
             end
        endcase
        case (tx_st0)
          0: if (tx_fs) begin
               chk("tx_has_frame", 32'(sb.size() > 0), 32'd1);
               if (sb.size() > 0) begin
                 e = sb.pop_front();
                 chk("tx_addr", 32'(tx_addr), 32'(e.addr));
                 chk("tx_frame", 32'(tx_frame), 32'(e.frame));
               end
               tx_cnt = 0;
               tx_st  = 1;
             end
          1: begin
               tx_cnt++;
               if (tx_cnt >= tx_delay && !tx_block) begin tx_fd = 1'b1; tx_st = 2; end
             end
          2: if (!tx_fs) tx_st = 3;
          default: if (tx_drop) begin
               tx_fd = 1'b0;
               n_sent++;
               tx_st = 0;
             end
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; fifo_ready = 8'h00; tx_block = 1'b0; sync_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int stable = 0;
    for (int i = 0; i < 5000 && stable < 10; i++) begin
      @(negedge clk);
      if (!busy && !cp_fs && !tx_fs && !cp_fd && !tx_fd && sb.size() == 0 && cp_st == 0 && tx_st == 0)
        stable++;
      else
        stable = 0;
    end
    chk({tag, "_quiet"}, 32'(stable >= 10), 32'd1);
  endtask

  task automatic toggle_ready(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_ready = 8'h00;
      @(negedge clk);
      fifo_ready = 8'hFF;
      @(negedge clk);
    end
  endtask

  initial begin : main
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cp_fs", 32'(cp_fs), 32'd0);
    chk("rst_tx_fs", 32'(tx_fs), 32'd0);
    chk("rst_cp_addr", 32'(cp_addr), 32'h000);
    chk("rst_tx_addr", 32'(tx_addr), 32'h000);
    chk("rst_tx_frame", 32'(tx_frame), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // basic frame with a 600-cycle copy
    cp_delay = 600; tx_delay = 5;
    enable = 1'b1; fifo_ready = 8'hFF;
    for (int i = 0; i < 3000 && n_sent < 1; i++) @(negedge clk);
    chk("basic_first_sent", 32'(n_sent >= 1), 32'd1);
    for (int i = 0; i < 3000 && n_cp_start < 2; i++) @(negedge clk);
    chk("basic_second_copy", 32'(n_cp_start), 32'd2);
    enable = 1'b0;
    wait_quiet("basic");
    chk("basic_sent", 32'(n_sent), 32'd2);

    // back-pressure: sender stalls
    do_reset();
    cp_delay = 20; tx_block = 1'b1;
    enable = 1'b1; fifo_ready = 8'hFF;
    for (int i = 0; i < 2000 && !(n_cp_done == 2 && !busy); i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("bp_copies", 32'(n_cp_start), 32'd2);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_cp_fs", 32'(cp_fs), 32'd0);
    chk("bp_ovf1", 32'(ovf_cnt), 32'd1);
    toggle_ready(3);
    chk("bp_ovf4", 32'(ovf_cnt), 32'd4);
    tx_block = 1'b0;
    for (int i = 0; i < 2000 && n_cp_start < 3; i++) @(negedge clk);
    chk("bp_third_copy", 32'(n_cp_start), 32'd3);
    enable = 1'b0;
    wait_quiet("bp");
    chk("bp_sent", 32'(n_sent), 32'd3);

    // commit and free aligned in the same cycle
    do_reset();
    cp_delay = 30; tx_delay = 30; sync_mode = 1'b1;
    enable = 1'b1; fifo_ready = 8'hFF;
    for (int i = 0; i < 5000 && n_sent < 10; i++) @(negedge clk);
    chk("sim_sent10", 32'(n_sent >= 10), 32'd1);
    enable = 1'b0;
    wait_quiet("sim");
    chk("sim_no_loss", 32'(n_sent), 32'(n_cp_done));

    // enable dropped while cp_fs is high
    do_reset();
    cp_delay = 40; tx_delay = 5;
    enable = 1'b1; fifo_ready = 8'hFF;
    for (int i = 0; i < 200 && !cp_fs; i++) @(negedge clk);
    chk("en_fill_seen", 32'(cp_fs), 32'd1);
    enable = 1'b0;
    wait_quiet("en");
    repeat (50) @(negedge clk);
    chk("en_copies", 32'(n_cp_start), 32'd1);
    chk("en_sent", 32'(n_sent), 32'd1);

    // partial readiness, then start latency
    do_reset();
    enable = 1'b1; fifo_ready = 8'h7F;
    repeat (50) @(negedge clk);
    chk("part_copies", 32'(n_cp_start), 32'd0);
    chk("part_cp_fs", 32'(cp_fs), 32'd0);
    chk("part_ovf", 32'(ovf_cnt), 32'd0);
    fifo_ready = 8'hFF;
    @(negedge clk);
    chk("lat_fs_low", 32'(cp_fs), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_addr", 32'(cp_addr), 32'h000);
    @(negedge clk);
    chk("lat_fs_high", 32'(cp_fs), 32'd1);
    enable = 1'b0;
    wait_quiet("part");

    // asynchronous reset during a fill
    do_reset();
    cp_delay = 40; tx_delay = 5;
    enable = 1'b1; fifo_ready = 8'hFF;
    for (int i = 0; i < 1000 && n_sent < 1; i++) @(negedge clk);
    tx_block = 1'b1;
    for (int i = 0; i < 1000 && !(cp_fs && tx_fs && n_cp_start >= 3); i++) @(negedge clk);
    chk("rm_pre_tx_fs", 32'(tx_fs), 32'd1);
    chk("rm_pre_tx_addr", 32'(tx_addr), 32'h200);
    chk("rm_pre_tx_frame", 32'(tx_frame), 32'd1);
    chk("rm_pre_cp_fs", 32'(cp_fs), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rm_cp_fs", 32'(cp_fs), 32'd0);
    chk("rm_tx_fs", 32'(tx_fs), 32'd0);
    chk("rm_cp_addr", 32'(cp_addr), 32'h000);
    chk("rm_tx_addr", 32'(tx_addr), 32'h000);
    chk("rm_tx_frame", 32'(tx_frame), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    tx_block = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 1000 && n_sent < 1; i++) @(negedge clk);
    chk("rm_resent", 32'(n_sent >= 1), 32'd1);
    enable = 1'b0;
    wait_quiet("rm");

    // overflow counter saturation
    do_reset();
    cp_delay = 10; tx_block = 1'b1;
    enable = 1'b1; fifo_ready = 8'hFF;
    for (int i = 0; i < 2000 && !(n_cp_done == 2 && !busy); i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("sat_ovf1", 32'(ovf_cnt), 32'd1);
    toggle_ready(253);
    chk("sat_ovf_fe", 32'(ovf_cnt), 32'hFE);
    toggle_ready(1);
    chk("sat_ovf_ff", 32'(ovf_cnt), 32'hFF);
    toggle_ready(46);
    chk("sat_ovf_hold", 32'(ovf_cnt), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
